// File: rtl/cpu_mem_arbiter.sv
// Arbitrates CPU instruction fetches and data loads/stores onto a single shared memory port.
// One transaction is in flight at a time, and a data request wins over a fetch raised in the same cycle.
module cpu_mem_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PC,
    input  logic        Inst_Req_Valid,
    output logic        Inst_Req_Ready,
    output logic [31:0] Instruction,
    output logic        Inst_Valid,
    input  logic        Inst_Ready,
    input  logic [31:0] Address,
    input  logic        MemWrite,
    input  logic [31:0] Write_data,
    input  logic [3:0]  Write_strb,
    input  logic        MemRead,
    output logic        Mem_Req_Ready,
    output logic [31:0] Read_data,
    output logic        Read_data_Valid,
    input  logic        Read_data_Ready,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_wen,
    output logic [31:0] mem_req_wdata,
    output logic [3:0]  mem_req_wstrb,
    input  logic        mem_rsp_valid,
    output logic        mem_rsp_ready,
    input  logic [31:0] mem_rsp_data,
    output logic [31:0] perf_inst_cnt,
    output logic [31:0] perf_data_cnt,
    output logic [31:0] perf_wait_cnt
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} state_e;
    typedef enum logic {SRC_INST, SRC_DATA} src_e;

    state_e      state_q, state_d;
    src_e        src_q, src_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic        wen_q, wen_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] perf_inst_cnt_q, perf_inst_cnt_d;
    logic [31:0] perf_data_cnt_q, perf_data_cnt_d;
    logic [31:0] perf_wait_cnt_q, perf_wait_cnt_d;
    logic        grant_data, grant_inst;

    always_comb begin
        // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latch).
        state_d    = state_q;
        src_d      = src_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        wen_d      = wen_q;
        buf_d      = buf_q;
        grant_data = 1'b0;
        grant_inst = 1'b0;

        case (state_q)
            IDLE: begin
                // Grants are held off while reset is asserted so nothing is accepted and then lost.
                if (rst && (MemRead || MemWrite)) begin
                    grant_data = 1'b1;
                    addr_d     = Address;
                    wen_d      = MemWrite;
                    wdata_d    = MemWrite ? Write_data : 32'h0;
                    wstrb_d    = MemWrite ? Write_strb : 4'h0;
                    src_d      = SRC_DATA;
                    state_d    = REQ;
                end else if (rst && Inst_Req_Valid) begin
                    grant_inst = 1'b1;
                    addr_d     = PC;
                    wen_d      = 1'b0;
                    wdata_d    = 32'h0;
                    wstrb_d    = 4'h0;
                    src_d      = SRC_INST;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (mem_req_ready) state_d = wen_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (mem_rsp_valid) begin
                    buf_d   = mem_rsp_data;
                    state_d = RSP;
                end
            end
            RSP: begin
                if ((src_q == SRC_INST) ? Inst_Ready : Read_data_Ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        perf_inst_cnt_d = perf_inst_cnt_q + {31'h0, grant_inst};
        perf_data_cnt_d = perf_data_cnt_q + {31'h0, grant_data};
        perf_wait_cnt_d = perf_wait_cnt_q + {31'h0, state_q == WAIT};
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst) begin
            state_q         <= IDLE;
            src_q           <= SRC_INST;
            addr_q          <= 32'h0;
            wdata_q         <= 32'h0;
            wstrb_q         <= 4'h0;
            wen_q           <= 1'b0;
            buf_q           <= 32'h0;
            perf_inst_cnt_q <= 32'h0;
            perf_data_cnt_q <= 32'h0;
            perf_wait_cnt_q <= 32'h0;
        end else begin
            state_q         <= state_d;
            src_q           <= src_d;
            addr_q          <= addr_d;
            wdata_q         <= wdata_d;
            wstrb_q         <= wstrb_d;
            wen_q           <= wen_d;
            buf_q           <= buf_d;
            perf_inst_cnt_q <= perf_inst_cnt_d;
            perf_data_cnt_q <= perf_data_cnt_d;
            perf_wait_cnt_q <= perf_wait_cnt_d;
        end
    end

    assign Mem_Req_Ready   = grant_data;
    assign Inst_Req_Ready  = grant_inst;
    assign mem_req_valid   = (state_q == REQ);
    assign mem_req_addr    = addr_q;
    assign mem_req_wen     = wen_q;
    assign mem_req_wdata   = wdata_q;
    assign mem_req_wstrb   = wstrb_q;
    assign mem_rsp_ready   = (state_q == WAIT);
    assign Instruction     = buf_q;
    assign Read_data       = buf_q;
    assign Inst_Valid      = (state_q == RSP) && (src_q == SRC_INST);
    assign Read_data_Valid = (state_q == RSP) && (src_q == SRC_DATA);
    assign perf_inst_cnt   = perf_inst_cnt_q;
    assign perf_data_cnt   = perf_data_cnt_q;
    assign perf_wait_cnt   = perf_wait_cnt_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: fetch, priority, store, backpressure, reset abandon, counter wrap.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC;
    logic        Inst_Req_Valid;
    logic        Inst_Req_Ready;
    logic [31:0] Instruction;
    logic        Inst_Valid;
    logic        Inst_Ready;
    logic [31:0] Address;
    logic        MemWrite;
    logic [31:0] Write_data;
    logic [3:0]  Write_strb;
    logic        MemRead;
    logic        Mem_Req_Ready;
    logic [31:0] Read_data;
    logic        Read_data_Valid;
    logic        Read_data_Ready;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid;
    logic        mem_rsp_ready;
    logic [31:0] mem_rsp_data;
    logic [31:0] perf_inst_cnt;
    logic [31:0] perf_data_cnt;
    logic [31:0] perf_wait_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .PC(PC), .Inst_Req_Valid(Inst_Req_Valid), .Inst_Req_Ready(Inst_Req_Ready),
        .Instruction(Instruction), .Inst_Valid(Inst_Valid), .Inst_Ready(Inst_Ready),
        .Address(Address), .MemWrite(MemWrite), .Write_data(Write_data), .Write_strb(Write_strb),
        .MemRead(MemRead), .Mem_Req_Ready(Mem_Req_Ready),
        .Read_data(Read_data), .Read_data_Valid(Read_data_Valid), .Read_data_Ready(Read_data_Ready),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_req_wen(mem_req_wen), .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .perf_inst_cnt(perf_inst_cnt), .perf_data_cnt(perf_data_cnt), .perf_wait_cnt(perf_wait_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; PC = '0; Inst_Req_Valid = 1'b0; Inst_Ready = 1'b0;
        Address = '0; MemWrite = 1'b0; Write_data = '0; Write_strb = '0; MemRead = 1'b0;
        Read_data_Ready = 1'b0; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_inst_req_ready", {31'h0, Inst_Req_Ready}, 32'h0);
        check("rst_mem_req_ready", {31'h0, Mem_Req_Ready}, 32'h0);
        check("rst_mem_req_valid", {31'h0, mem_req_valid}, 32'h0);
        check("rst_mem_rsp_ready", {31'h0, mem_rsp_ready}, 32'h0);
        check("rst_valids", {30'h0, Inst_Valid, Read_data_Valid}, 32'h0);
        check("rst_instruction", Instruction, 32'h0);
        check("rst_perf_sum", perf_inst_cnt | perf_data_cnt | perf_wait_cnt, 32'h0);

        // Fetch with two memory wait cycles.
        PC = 32'h100; Inst_Req_Valid = 1'b1; mem_req_ready = 1'b1;
        #1 check("f_inst_req_ready", {31'h0, Inst_Req_Ready}, 32'h1);
        tick(); Inst_Req_Valid = 1'b0; #1;
        check("f_req_valid", {31'h0, mem_req_valid}, 32'h1);
        check("f_req_addr", mem_req_addr, 32'h100);
        check("f_req_wen", {31'h0, mem_req_wen}, 32'h0);
        check("f_req_wdata", mem_req_wdata, 32'h0);
        tick(); mem_req_ready = 1'b0;
        check("f_rsp_ready", {31'h0, mem_rsp_ready}, 32'h1);
        tick(); tick();
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00000013;
        tick(); mem_rsp_valid = 1'b0;
        check("f_inst_valid_c5", {31'h0, Inst_Valid}, 32'h1);
        check("f_instruction", Instruction, 32'h00000013);
        check("f_rd_valid", {31'h0, Read_data_Valid}, 32'h0);
        check("f_perf_inst", perf_inst_cnt, 32'd1);
        check("f_perf_wait", perf_wait_cnt, 32'd3);
        Inst_Ready = 1'b1;
        tick(); Inst_Ready = 1'b0; #1;
        check("f_inst_valid_done", {31'h0, Inst_Valid}, 32'h0);

        // Simultaneous fetch and load: data first.
        PC = 32'h300; Inst_Req_Valid = 1'b1; MemRead = 1'b1; Address = 32'h2000; mem_req_ready = 1'b1;
        #1;
        check("s_mem_req_ready", {31'h0, Mem_Req_Ready}, 32'h1);
        check("s_inst_req_ready", {31'h0, Inst_Req_Ready}, 32'h0);
        tick(); MemRead = 1'b0; #1;
        check("s_req_addr", mem_req_addr, 32'h2000);
        check("s_inst_blocked_req", {31'h0, Inst_Req_Ready}, 32'h0);
        tick(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE0001;
        tick(); mem_rsp_valid = 1'b0; #1;
        check("s_rd_valid", {31'h0, Read_data_Valid}, 32'h1);
        check("s_read_data", Read_data, 32'hCAFE0001);
        check("s_inst_valid", {31'h0, Inst_Valid}, 32'h0);
        check("s_inst_blocked_rsp", {31'h0, Inst_Req_Ready}, 32'h0);
        Read_data_Ready = 1'b1;
        tick(); Read_data_Ready = 1'b0; #1;
        check("s_inst_granted", {31'h0, Inst_Req_Ready}, 32'h1);
        check("s_perf_data", perf_data_cnt, 32'd1);
        tick(); Inst_Req_Valid = 1'b0; #1;
        check("s_fetch_addr", mem_req_addr, 32'h300);
        tick(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h11111111;
        tick(); mem_rsp_valid = 1'b0; Inst_Ready = 1'b1; #1;
        check("s_fetch_instr", Instruction, 32'h11111111);
        tick(); Inst_Ready = 1'b0; #1;
        check("s_perf_inst", perf_inst_cnt, 32'd2);

        // Store, then read+write with zero strobe treated as a write.
        MemWrite = 1'b1; Address = 32'h40; Write_data = 32'hDEADBEEF; Write_strb = 4'b0011;
        #1 check("w_mem_req_ready", {31'h0, Mem_Req_Ready}, 32'h1);
        tick(); MemWrite = 1'b0; Address = 32'h999; Write_data = 32'h0; #1;
        check("w_req_valid", {31'h0, mem_req_valid}, 32'h1);
        check("w_req_wen", {31'h0, mem_req_wen}, 32'h1);
        check("w_req_addr", mem_req_addr, 32'h40);
        check("w_req_wdata", mem_req_wdata, 32'hDEADBEEF);
        check("w_req_wstrb", {28'h0, mem_req_wstrb}, 32'h3);
        tick();
        check("w_idle_valid", {31'h0, mem_req_valid}, 32'h0);
        check("w_no_rsp_ready", {31'h0, mem_rsp_ready}, 32'h0);
        check("w_no_rd_valid", {31'h0, Read_data_Valid}, 32'h0);
        MemRead = 1'b1; MemWrite = 1'b1; Address = 32'h44; Write_data = 32'h55; Write_strb = 4'b0000;
        tick(); MemRead = 1'b0; MemWrite = 1'b0; #1;
        check("rw_wen", {31'h0, mem_req_wen}, 32'h1);
        check("rw_zero_strb_issued", {27'h0, mem_req_valid, mem_req_wstrb}, 32'h10);
        tick();
        check("rw_back_idle", {31'h0, mem_req_valid}, 32'h0);

        // Backpressure on both sides.
        MemRead = 1'b1; Address = 32'h80; Write_data = 32'h12345678; mem_req_ready = 1'b0;
        tick(); MemRead = 1'b0; Address = 32'h0; #1;
        for (int i = 0; i < 4; i++) begin
            check("bp_req_valid", {31'h0, mem_req_valid}, 32'h1);
            check("bp_req_addr", mem_req_addr, 32'h80);
            check("bp_req_wdata", mem_req_wdata, 32'h0);
            tick();
        end
        mem_req_ready = 1'b1;
        tick(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'hA5A5A5A5;
        tick(); mem_rsp_valid = 1'b0; mem_rsp_data = 32'h0;
        for (int i = 0; i < 3; i++) begin
            check("bp_rd_valid", {31'h0, Read_data_Valid}, 32'h1);
            check("bp_read_data", Read_data, 32'hA5A5A5A5);
            tick();
        end
        Read_data_Ready = 1'b1;
        tick(); Read_data_Ready = 1'b0; #1;
        check("bp_rd_done", {31'h0, Read_data_Valid}, 32'h0);

        // Reset while waiting for a response; late response is ignored.
        PC = 32'h500; Inst_Req_Valid = 1'b1;
        tick(); Inst_Req_Valid = 1'b0;
        tick();
        check("r_in_wait", {31'h0, mem_rsp_ready}, 32'h1);
        rst = 1'b0;
        tick(); rst = 1'b1;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00000BAD; #1;
        check("r_rsp_ready_idle", {31'h0, mem_rsp_ready}, 32'h0);
        check("r_perf_zero", perf_inst_cnt | perf_data_cnt | perf_wait_cnt, 32'h0);
        tick(); mem_rsp_valid = 1'b0; #1;
        check("r_no_valids", {30'h0, Inst_Valid, Read_data_Valid}, 32'h0);
        check("r_buffer_clear", Instruction, 32'h0);
        PC = 32'h600; Inst_Req_Valid = 1'b1;
        #1 check("r_fetch_ready", {31'h0, Inst_Req_Ready}, 32'h1);
        tick(); Inst_Req_Valid = 1'b0; #1;
        check("r_fetch_addr", mem_req_addr, 32'h600);
        tick(); mem_rsp_valid = 1'b1; mem_rsp_data = 32'h00000077;
        tick(); mem_rsp_valid = 1'b0; #1;
        check("r_fetch_valid", {31'h0, Inst_Valid}, 32'h1);
        check("r_fetch_instr", Instruction, 32'h00000077);
        check("r_perf_inst", perf_inst_cnt, 32'd1);
        check("r_perf_wait", perf_wait_cnt, 32'd1);
        Inst_Ready = 1'b1;
        tick(); Inst_Ready = 1'b0;

        // Data counter wrap.
        force dut.perf_data_cnt_q = 32'hFFFFFFFF;
        #1 release dut.perf_data_cnt_q;
        MemRead = 1'b1; Address = 32'h10;
        tick(); MemRead = 1'b0; #1;
        check("wrap_perf_data", perf_data_cnt, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
